lc3_mio_ctrl: RTL and testbench

- Parametrised memory/IO controller for the LC-3 datapath. It owns the MAR and MDR and arbitrates each access between memory-mapped device registers and an external, handshaked memory port with wait states and timeout.
- Device registers: keyboard and display status/data registers, plus an interrupt pending/mask pair.
- A registered priority encoder turns device and external interrupt sources into a request, priority level and vector for the control FSM.

---
 rtl/lc3_mio_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_lc3_mio_ctrl.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mio_ctrl.sv
// LC-3 memory/IO controller: MAR/MDR, device registers,
// handshaked memory port with timeout, interrupt encoder.
module lc3_mio_ctrl #(
  parameter int             DW           = 16,
  parameter logic [DW-1:0]  IO_BASE      = 16'hFE00,
  parameter int             N_IRQ        = 2,
  parameter logic [7:0]     EXT_VEC_BASE = 8'hC0,
  parameter int             TIMEOUT      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    bus,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             mio_en,
  input  logic             r_w,
  input  logic             gate_mdr,
  output logic [DW-1:0]    mdr_out,
  output logic             ready,
  output logic             bus_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [DW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_ack,
  input  logic [7:0]       kb_data,
  input  logic             kb_valid,
  output logic [7:0]       disp_data,
  output logic             disp_valid,
  input  logic             disp_ack,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             int_req,
  output logic [2:0]       int_pri,
  output logic [7:0]       int_vec,
  input  logic             int_ack
);

  localparam int CW = $clog2(TIMEOUT);

  localparam logic [DW-1:0] OFF_KBSR = DW'(0);
  localparam logic [DW-1:0] OFF_KBDR = DW'(2);
  localparam logic [DW-1:0] OFF_DSR  = DW'(4);
  localparam logic [DW-1:0] OFF_DDR  = DW'(6);
  localparam logic [DW-1:0] OFF_ISR  = DW'(8);
  localparam logic [DW-1:0] OFF_IMR  = DW'(10);

  typedef enum logic [1:0] {
    S_IDLE, S_IO, S_MEM, S_DONE
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   mar_q;
  logic [DW-1:0]   mdr_q;
  logic            we_q;
  logic [CW-1:0]   cnt_q;
  logic            ready_q;
  logic            bus_err_q;
  logic            mem_req_q;
  logic            mem_we_q;

  logic            kb_rdy_q;
  logic            kb_ie_q;
  logic            kb_ovr_q;
  logic [7:0]      kbdr_q;
  logic            ds_rdy_q;
  logic            ds_ie_q;
  logic [7:0]      ddr_q;
  logic            disp_valid_q;
  logic [N_IRQ-1:0] isr_q;
  logic [N_IRQ-1:0] isr_d;
  logic [N_IRQ-1:0] imr_q;

  logic            int_req_q;
  logic            int_req_d;
  logic [2:0]      int_pri_q;
  logic [2:0]      int_pri_d;
  logic [7:0]      int_vec_q;
  logic [7:0]      int_vec_d;

  logic [DW-1:0]   off;
  logic [DW-1:0]   io_rdata;
  logic            io_wr;
  logic            io_rd;

  assign off   = mar_q - IO_BASE;
  assign io_wr = (state_q == S_IO) && we_q;
  assign io_rd = (state_q == S_IO) && !we_q;

  assign mdr_out    = gate_mdr ? mdr_q : {DW{1'bz}};
  assign ready      = ready_q;
  assign bus_err    = bus_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mar_q;
  assign mem_wdata  = mdr_q;
  assign disp_data  = ddr_q;
  assign disp_valid = disp_valid_q;
  assign int_req    = int_req_q;
  assign int_pri    = int_pri_q;
  assign int_vec    = int_vec_q;

  // Device register read mux; unmapped offsets read 0.
  always_comb begin
    io_rdata = '0;
    case (off)
      OFF_KBSR: begin
        io_rdata[15] = kb_rdy_q;
        io_rdata[14] = kb_ie_q;
        io_rdata[13] = kb_ovr_q;
      end
      OFF_KBDR: io_rdata[7:0] = kbdr_q;
      OFF_DSR: begin
        io_rdata[15] = ds_rdy_q;
        io_rdata[14] = ds_ie_q;
      end
      OFF_DDR: io_rdata[7:0] = ddr_q;
      OFF_ISR: io_rdata[N_IRQ-1:0] = isr_q;
      OFF_IMR: io_rdata[N_IRQ-1:0] = imr_q;
      default: io_rdata = '0;
    endcase
  end

  // Access FSM owning MAR, MDR and the memory handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      bus_err_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (ld_mar) mar_q <= bus;
          if (ld_mdr) mdr_q <= bus;
          if (mio_en) begin
            we_q    <= r_w;
            ready_q <= 1'b0;
            if (mar_q >= IO_BASE) begin
              state_q <= S_IO;
            end else begin
              state_q   <= S_MEM;
              mem_req_q <= 1'b1;
              mem_we_q  <= r_w;
              cnt_q     <= '0;
            end
          end
        end
        S_IO: begin
          if (!we_q) mdr_q <= io_rdata;
          state_q <= S_DONE;
        end
        S_MEM: begin
          if (mem_ack) begin
            if (!we_q) mdr_q <= mem_rdata;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= S_DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            if (!we_q) mdr_q <= DW'(16'hDEAD);
            bus_err_q <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Keyboard status/data; a new strobe beats a KBDR read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb_rdy_q <= 1'b0;
      kb_ie_q  <= 1'b0;
      kb_ovr_q <= 1'b0;
      kbdr_q   <= '0;
    end else begin
      if (io_rd && off == OFF_KBDR) kb_rdy_q <= 1'b0;
      if (io_wr && off == OFF_KBSR) begin
        kb_ie_q <= mdr_q[14];
        if (mdr_q[13]) kb_ovr_q <= 1'b0;
      end
      if (kb_valid) begin
        kbdr_q   <= kb_data;
        kb_rdy_q <= 1'b1;
        if (kb_rdy_q) kb_ovr_q <= 1'b1;
      end
    end
  end

  // Display status/data handshake with the output device.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_rdy_q     <= 1'b1;
      ds_ie_q      <= 1'b0;
      ddr_q        <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      if (io_wr && off == OFF_DSR) ds_ie_q <= mdr_q[14];
      if (disp_valid_q && disp_ack) begin
        disp_valid_q <= 1'b0;
        ds_rdy_q     <= 1'b1;
      end
      if (io_wr && off == OFF_DDR && ds_rdy_q) begin
        ddr_q        <= mdr_q[7:0];
        ds_rdy_q     <= 1'b0;
        disp_valid_q <= 1'b1;
      end
    end
  end

  // Pending bits: clears from writes and acks, sets win.
  always_comb begin
    isr_d = isr_q;
    if (io_wr && off == OFF_ISR)
      isr_d = isr_d & ~mdr_q[N_IRQ-1:0];
    if (int_ack && int_req_q) begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (int_vec_q == EXT_VEC_BASE + 8'(i))
          isr_d[i] = 1'b0;
      end
    end
    isr_d = isr_d | irq_in;
  end

  // Priority select; later assignments win.
  always_comb begin
    int_req_d = 1'b0;
    int_pri_d = 3'd0;
    int_vec_d = 8'h00;
    if (ds_rdy_q && ds_ie_q) begin
      int_req_d = 1'b1;
      int_pri_d = 3'd4;
      int_vec_d = 8'h81;
    end
    if (kb_rdy_q && kb_ie_q) begin
      int_req_d = 1'b1;
      int_pri_d = 3'd4;
      int_vec_d = 8'h80;
    end
    for (int i = 0; i < N_IRQ; i++) begin
      if (isr_q[i] && imr_q[i]) begin
        int_req_d = 1'b1;
        int_pri_d = 3'(5 + i);
        int_vec_d = EXT_VEC_BASE + 8'(i);
      end
    end
  end

  // Interrupt pending/mask and registered request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isr_q     <= '0;
      imr_q     <= '0;
      int_req_q <= 1'b0;
      int_pri_q <= 3'd0;
      int_vec_q <= 8'h00;
    end else begin
      isr_q <= isr_d;
      if (io_wr && off == OFF_IMR) imr_q <= mdr_q[N_IRQ-1:0];
      int_req_q <= int_req_d;
      int_pri_q <= int_pri_d;
      int_vec_q <= int_vec_d;
    end
  end

endmodule

// File: tb/tb_lc3_mio_ctrl.sv
// Directed bench for lc3_mio_ctrl: memory port,
// device registers and interrupt encoder.
module tb_lc3_mio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus;
  logic        ld_mar, ld_mdr, mio_en, r_w, gate_mdr;
  logic [15:0] mdr_out;
  logic        ready, bus_err, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [7:0]  kb_data;
  logic        kb_valid;
  logic [7:0]  disp_data;
  logic        disp_valid, disp_ack;
  logic [1:0]  irq_in;
  logic        int_req;
  logic [2:0]  int_pri;
  logic [7:0]  int_vec;
  logic        int_ack;

  int ncmp = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  lc3_mio_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w),
    .gate_mdr(gate_mdr), .mdr_out(mdr_out),
    .ready(ready), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .kb_data(kb_data), .kb_valid(kb_valid),
    .disp_data(disp_data), .disp_valid(disp_valid),
    .disp_ack(disp_ack), .irq_in(irq_in),
    .int_req(int_req), .int_pri(int_pri),
    .int_vec(int_vec), .int_ack(int_ack)
  );

  task automatic rd_mdr(output logic [15:0] v);
    gate_mdr = 1'b1;
    #1 v = mdr_out;
    gate_mdr = 1'b0;
  endtask

  task automatic start(input logic [15:0] a,
                       input logic [15:0] wd,
                       input logic wr);
    bus = a; ld_mar = 1'b1;
    @(negedge clk);
    ld_mar = 1'b0;
    bus = wd; ld_mdr = 1'b1;
    @(negedge clk);
    ld_mdr = 1'b0;
    mio_en = 1'b1; r_w = wr;
  endtask

  task automatic io_acc(input logic [15:0] a,
                        input logic [15:0] wd,
                        input logic wr,
                        output logic [15:0] rd,
                        output int busy);
    start(a, wd, wr);
    @(negedge clk);
    mio_en = 1'b0; r_w = 1'b0;
    busy = 0;
    while (!ready && busy < 200) begin
      busy++;
      @(negedge clk);
    end
    ncmp++;
    if (!ready) begin
      nmis++;
      $display("FAIL io_done: ready=%b want 1", ready);
    end
    rd_mdr(rd);
  endtask

  task automatic test_reset;
    logic [15:0] v;
    int b;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ncmp++;
    if ({ready, bus_err, mem_req} !== 3'b100) begin
      nmis++;
      $display("FAIL rst_ctl: got %b want 100",
               {ready, bus_err, mem_req});
    end
    ncmp++;
    if ({int_req, int_pri, int_vec} !== 12'h000) begin
      nmis++;
      $display("FAIL rst_int: got %h want 000",
               {int_req, int_pri, int_vec});
    end
    ncmp++;
    if (disp_valid !== 1'b0) begin
      nmis++;
      $display("FAIL rst_disp: got %b want 0", disp_valid);
    end
    rd_mdr(v);
    ncmp++;
    if (v !== 16'h0000) begin
      nmis++;
      $display("FAIL rst_mdr: got %h want 0000", v);
    end
    io_acc(16'hFE04, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h8000) begin
      nmis++;
      $display("FAIL rst_dsr: got %h want 8000", v);
    end
    ncmp++;
    if (b !== 2) begin
      nmis++;
      $display("FAIL io_busy: got %0d want 2", b);
    end
  endtask

  task automatic test_reset_mid_mem;
    logic [15:0] v;
    int b;
    start(16'h3000, 16'h5A5A, 1'b0);
    repeat (2) @(negedge clk);
    mio_en = 1'b0;
    ncmp++;
    if (mem_req !== 1'b1) begin
      nmis++;
      $display("FAIL mid_req: got %b want 1", mem_req);
    end
    rst = 1'b1;
    #1;
    ncmp++;
    if ({mem_req, ready} !== 2'b01) begin
      nmis++;
      $display("FAIL mid_rst: req/rdy=%b want 01",
               {mem_req, ready});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_mdr(v);
    ncmp++;
    if (v !== 16'h0000) begin
      nmis++;
      $display("FAIL mid_mdr: got %h want 0000", v);
    end
    io_acc(16'hFE04, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h8000) begin
      nmis++;
      $display("FAIL mid_dsr: got %h want 8000", v);
    end
  endtask

  task automatic test_mem_read;
    logic [15:0] v;
    int busy = 0;
    int bad = 0;
    start(16'h3000, 16'hFFFF, 1'b0);
    mem_rdata = 16'h1234;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      mio_en = 1'b0;
      if (ready) break;
      busy++;
      if (mem_req && (mem_addr !== 16'h3000 || mem_we))
        bad++;
      mem_ack = (i == 4);
    end
    mem_ack = 1'b0;
    ncmp++;
    if (busy !== 5) begin
      nmis++;
      $display("FAIL mrd_busy: got %0d want 5", busy);
    end
    ncmp++;
    if (bad !== 0) begin
      nmis++;
      $display("FAIL mrd_addr: bad=%0d want 0", bad);
    end
    rd_mdr(v);
    ncmp++;
    if (v !== 16'h1234) begin
      nmis++;
      $display("FAIL mrd_mdr: got %h want 1234", v);
    end
  endtask

  task automatic test_mem_write;
    int busy = 0;
    int ok = 0;
    start(16'h3100, 16'hBEEF, 1'b1);
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      mio_en = 1'b0; r_w = 1'b0;
      if (ready) break;
      busy++;
      if (mem_req && mem_we && mem_addr === 16'h3100
          && mem_wdata === 16'hBEEF)
        ok++;
      mem_ack = (i == 1);
    end
    mem_ack = 1'b0;
    ncmp++;
    if (busy !== 2) begin
      nmis++;
      $display("FAIL mwr_busy: got %0d want 2", busy);
    end
    ncmp++;
    if (ok !== 1) begin
      nmis++;
      $display("FAIL mwr_bus: req cycles ok=%0d want 1", ok);
    end
  endtask

  task automatic test_timeout;
    logic [15:0] v;
    int busy = 0;
    int reqc = 0;
    int errc = 0;
    int bad = 0;
    start(16'h3000, 16'h7777, 1'b0);
    for (int i = 1; i < 300; i++) begin
      @(negedge clk);
      mio_en = 1'b0;
      ld_mar = (i == 5);
      ld_mdr = (i == 5);
      bus = 16'h1111;
      if (ready) break;
      busy++;
      if (mem_req) reqc++;
      if (bus_err) errc++;
      if (mem_req && mem_addr !== 16'h3000) bad++;
    end
    ld_mar = 1'b0; ld_mdr = 1'b0;
    ncmp++;
    if (reqc !== 64) begin
      nmis++;
      $display("FAIL to_req: got %0d want 64", reqc);
    end
    ncmp++;
    if (errc !== 1) begin
      nmis++;
      $display("FAIL to_err: got %0d want 1", errc);
    end
    ncmp++;
    if (busy !== 65 || bad !== 0) begin
      nmis++;
      $display("FAIL to_busy: busy=%0d bad=%0d want 65/0",
               busy, bad);
    end
    rd_mdr(v);
    ncmp++;
    if (v !== 16'hDEAD) begin
      nmis++;
      $display("FAIL to_mdr: got %h want DEAD", v);
    end
  endtask

  task automatic kb_strobe(input logic [7:0] c);
    kb_data = c; kb_valid = 1'b1;
    @(negedge clk);
    kb_valid = 1'b0;
  endtask

  task automatic test_keyboard;
    logic [15:0] v;
    int b;
    kb_strobe(8'h41);
    io_acc(16'hFE00, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h8000) begin
      nmis++;
      $display("FAIL kbsr1: got %h want 8000", v);
    end
    kb_strobe(8'h41);
    io_acc(16'hFE00, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'hA000) begin
      nmis++;
      $display("FAIL kbsr2: got %h want A000", v);
    end
    io_acc(16'hFE02, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h0041) begin
      nmis++;
      $display("FAIL kbdr: got %h want 0041", v);
    end
    io_acc(16'hFE00, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h2000) begin
      nmis++;
      $display("FAIL kbsr3: got %h want 2000", v);
    end
    io_acc(16'hFE00, 16'h2000, 1'b1, v, b);
    io_acc(16'hFE00, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h0000) begin
      nmis++;
      $display("FAIL kbsr_w1c: got %h want 0000", v);
    end
  endtask

  task automatic test_display;
    logic [15:0] v;
    int b;
    io_acc(16'hFE04, 16'h4000, 1'b1, v, b);
    io_acc(16'hFE06, 16'h0048, 1'b1, v, b);
    ncmp++;
    if ({disp_valid, disp_data} !== 9'h148) begin
      nmis++;
      $display("FAIL ddr_wr: got %h want 148",
               {disp_valid, disp_data});
    end
    io_acc(16'hFE04, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h4000) begin
      nmis++;
      $display("FAIL dsr_busy: got %h want 4000", v);
    end
    io_acc(16'hFE06, 16'h0055, 1'b1, v, b);
    ncmp++;
    if (disp_data !== 8'h48 || int_req !== 1'b0) begin
      nmis++;
      $display("FAIL ddr_drop: data=%h req=%b want 48/0",
               disp_data, int_req);
    end
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
    @(negedge clk);
    ncmp++;
    if ({disp_valid, int_req, int_pri, int_vec}
        !== {1'b0, 1'b1, 3'd4, 8'h81}) begin
      nmis++;
      $display("FAIL disp_int: v=%b req=%b pri=%0d vec=%h %s",
               disp_valid, int_req, int_pri, int_vec,
               "want 0/1/4/81");
    end
    io_acc(16'hFE04, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'hC000) begin
      nmis++;
      $display("FAIL dsr_ack: got %h want C000", v);
    end
  endtask

  task automatic ack_once;
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_irq;
    logic [15:0] v;
    int b;
    io_acc(16'hFE0A, 16'h0003, 1'b1, v, b);
    io_acc(16'hFE00, 16'h4000, 1'b1, v, b);
    kb_strobe(8'h42);
    irq_in = 2'b11;
    @(negedge clk);
    irq_in = 2'b00;
    @(negedge clk);
    ncmp++;
    if ({int_req, int_pri, int_vec} !== {1'b1, 3'd6, 8'hC1}) begin
      nmis++;
      $display("FAIL irq_c1: pri=%0d vec=%h want 6/C1",
               int_pri, int_vec);
    end
    io_acc(16'hFE08, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h0003) begin
      nmis++;
      $display("FAIL isr_rd: got %h want 0003", v);
    end
    ack_once();
    ncmp++;
    if ({int_req, int_pri, int_vec} !== {1'b1, 3'd5, 8'hC0}) begin
      nmis++;
      $display("FAIL irq_c0: pri=%0d vec=%h want 5/C0",
               int_pri, int_vec);
    end
    ack_once();
    ncmp++;
    if ({int_req, int_pri, int_vec} !== {1'b1, 3'd4, 8'h80}) begin
      nmis++;
      $display("FAIL irq_kb: pri=%0d vec=%h want 4/80",
               int_pri, int_vec);
    end
    irq_in = 2'b01;
    io_acc(16'hFE08, 16'h0001, 1'b1, v, b);
    io_acc(16'hFE08, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h0001) begin
      nmis++;
      $display("FAIL isr_setwin: got %h want 0001", v);
    end
    irq_in = 2'b00;
    io_acc(16'hFE08, 16'h0001, 1'b1, v, b);
    io_acc(16'hFE08, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h0000 || int_vec !== 8'h80) begin
      nmis++;
      $display("FAIL isr_clr: isr=%h vec=%h want 0000/80",
               v, int_vec);
    end
  endtask

  task automatic test_other_offset;
    logic [15:0] v;
    int b;
    io_acc(16'hFE0C, 16'h1234, 1'b1, v, b);
    io_acc(16'hFE0C, 16'hFFFF, 1'b0, v, b);
    ncmp++;
    if (v !== 16'h0000 || b !== 2) begin
      nmis++;
      $display("FAIL io_other: got %h busy=%0d want 0000/2",
               v, b);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus = '0; ld_mar = 0; ld_mdr = 0;
    mio_en = 0; r_w = 0; gate_mdr = 0;
    mem_rdata = '0; mem_ack = 0;
    kb_data = '0; kb_valid = 0;
    disp_ack = 0; irq_in = '0; int_ack = 0;
    test_reset();
    test_reset_mid_mem();
    test_mem_read();
    test_mem_write();
    test_timeout();
    test_keyboard();
    test_display();
    test_irq();
    test_other_offset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nmis);
    $finish;
  end

endmodule
